// File: rtl/btn_debounce_toggle_if.sv
// Button conditioner interface: raw button and toggle clear in,
// debounced level, pulses and toggle out.
interface btn_debounce_toggle_if;
  logic btn;
  logic tgl_clr;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic toggle;
  logic long_pulse;

  // Board / stimulus side
  modport master (
    output btn, tgl_clr,
    input  btn_level, press_pulse, release_pulse, toggle, long_pulse
  );

  // Conditioner side
  modport slave (
    input  btn, tgl_clr,
    output btn_level, press_pulse, release_pulse, toggle, long_pulse
  );
endinterface

// File: rtl/btn_debounce_toggle.sv
// Push-button conditioner: two-flop synchroniser, four-state debounce FSM
// with a shared counter, registered press/release strobes and a toggle.
// Optional long-press strobe is enabled by defining BTN_LONG_PRESS_EN;
// without it long_pulse stays 0 and HELD does not count.
module btn_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btn_debounce_toggle_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM_PRESS, HELD, ARM_REL} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  // Counter parks one past the strobe point so the strobe fires once per hold.
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s1_d, s2_q, s2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic             long_q, long_d;

  // Next-state, counter and registered output values
  always_comb begin
    s1_d      = bus.btn;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = ARM_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = ARM_REL;
          cnt_d   = CNT_ONE;
        end else begin
`ifdef BTN_LONG_PRESS_EN
          if (cnt_q != LONG_SAT) begin
            cnt_d  = cnt_q + CNT_ONE;
            long_d = (cnt_q == LONG_LAST);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      ARM_REL: begin
        if (s2_q) begin
          state_d   = HELD;
          cnt_d     = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Clear beats a press landing on the same edge
    if (bus.tgl_clr)  toggle_d = 1'b0;
    else if (press_d) toggle_d = ~toggle_q;
    else              toggle_d = toggle_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      long_q    <= long_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;
  assign bus.long_pulse    = long_q;

endmodule
